mem_ctrl: RTL

- Single-port memory controller that sequences instruction fetch and data load/store over the byte-wide RAM bus.
- Arbitrates between the fetch stage (pc_reg) and the MEM stage.
- Splits each 1/2/4-byte access into sequential byte cycles and assembles or disassembles 32-bit words in little-endian order.
- Sits between the pipeline front/back ends and the external RAM.

---
 rtl/mem_ctrl_pkg.sv | 47 ++++
 rtl/mem_ctrl_arb.sv | 42 ++++
 rtl/mem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared definitions for the byte-wide memory controller:
//                access-size encodings, FSM state encoding, pipeline control
//                constants and a helper that maps an access size to the index
//                of its last byte.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access-size encodings on mem_size (2'b11 behaves as a word).
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    // Index of the last byte of a word access (fetches are always words).
    localparam logic [1:0] c_LAST_WORD = 2'd3;

    // Pipeline control constants shared with the rest of the core.
    localparam logic c_STOP          = 1'b1;
    localparam logic c_NO_STOP       = 1'b0;
    localparam logic c_MEMORY_ENABLE = 1'b1;
    localparam logic c_REORDER       = 1'b1;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte count minus one for a data access of the given size.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            c_SIZE_BYTE: last = 2'd0;
            c_SIZE_HALF: last = 2'd1;
            c_SIZE_WORD: last = c_LAST_WORD;
            default:     last = c_LAST_WORD;
        endcase
        return last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_arb
//  Description : Combinational grant logic evaluated while the controller is
//                idle. The data port has priority over instruction fetch. A
//                port that completed in the previous cycle is ignored for one
//                cycle (its requester drops a registered request one cycle
//                late). A fetch flush suppresses a fetch grant.
//  Ports       : i_idle      controller is in IDLE
//                i_if_req    fetch request level
//                i_mem_req   data request level
//                i_if_flush  fetch abort
//                i_cool_if   fetch port completed last cycle
//                i_cool_mem  data port completed last cycle
//                o_grant_if  fetch accepted this cycle
//                o_grant_mem data access accepted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_if_flush,
    input  logic i_cool_if,
    input  logic i_cool_mem,
    output logic o_grant_if,
    output logic o_grant_mem
);

    logic w_mem_ok;
    logic w_if_ok;

    assign w_mem_ok = i_idle & i_mem_req & ~i_cool_mem;
    assign w_if_ok  = i_idle & i_if_req & ~i_cool_if & (i_if_flush != c_REORDER);

    assign o_grant_mem = w_mem_ok;
    assign o_grant_if  = w_if_ok & ~w_mem_ok;

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Single-port controller sequencing instruction fetch and data
//                load/store over a byte-wide RAM. Each 1/2/4 byte access is
//                split into consecutive byte cycles; words are assembled and
//                disassembled little-endian. The RAM returns read data one
//                cycle after the address is presented.
//  Config      : MEMCTRL_PERF_EN - when defined, perf_if_cnt / perf_mem_cnt
//                count completed fetches / data accesses; otherwise both
//                outputs are tied to zero.
//  Ports       : clk, rst (async, active-low)
//                if_req/if_addr/if_flush -> if_ready/if_data   fetch port
//                mem_req/mem_we/mem_size/mem_addr/mem_wdata
//                                        -> mem_ready/mem_rdata data port
//                ram_a/ram_dout/ram_wr -> RAM, ram_din <- RAM
//                perf_if_cnt/perf_mem_cnt                     completion counts
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_mem_cnt
);

    // Only a one-cycle RAM read latency is implemented.
    if (RD_LAT != 1) begin : g_rd_lat_unsupported
        $error("mem_ctrl: RD_LAT must be 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_own_mem;     // 1: data port owns the bus, 0: fetch
    logic              r_we;          // current access is a store
    logic [1:0]        r_last;        // byte count minus one
    logic [1:0]        r_cnt;         // address byte index, saturates at r_last
    logic [1:0]        r_cap;         // next byte lane to capture on reads
    logic              r_cap_vld;     // ram_din carries a requested byte
    logic [ADDR_W-1:0] r_ram_a;
    logic [31:0]       r_wdata;       // store data, shifted down one byte per write
    logic [31:0]       r_buf;         // read assembly buffer, zero-filled on accept
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic              r_cool_if;
    logic              r_cool_mem;

    logic              w_grant_if;
    logic              w_grant_mem;
    logic              w_addr_last;
    logic              w_rd_last;
    logic              w_fetch_abort;
    logic              w_if_ready;
    logic              w_mem_ready;

    mem_ctrl_arb u_arb (
        .i_idle      (r_state == ST_IDLE),
        .i_if_req    (if_req),
        .i_mem_req   (mem_req),
        .i_if_flush  (if_flush),
        .i_cool_if   (r_cool_if),
        .i_cool_mem  (r_cool_mem),
        .o_grant_if  (w_grant_if),
        .o_grant_mem (w_grant_mem)
    );

    assign w_addr_last   = (r_cnt == r_last);
    assign w_rd_last     = r_cap_vld && (r_cap == r_last);
    // A flush only matters while the fetch owns the bus.
    assign w_fetch_abort = !r_own_mem && (if_flush == c_REORDER);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and ready pulses
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_if_ready  = 1'b0;
        w_mem_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_mem) begin
                    w_state_nxt = mem_we ? ST_WR : ST_RD;
                end else if (w_grant_if) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                // Reads stay here one cycle past the last address so the
                // final byte is captured before DONE.
                if (w_fetch_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rd_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WR: begin
                if (w_addr_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (r_own_mem) begin
                    w_mem_ready = 1'b1;
                end else if (!w_fetch_abort) begin
                    w_if_ready = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_own_mem   <= 1'b0;
            r_we        <= 1'b0;
            r_last      <= 2'd0;
            r_cnt       <= 2'd0;
            r_cap       <= 2'd0;
            r_cap_vld   <= 1'b0;
            r_ram_a     <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_cool_if   <= 1'b0;
            r_cool_mem  <= 1'b0;
        end else begin
            r_cool_if  <= w_if_ready;
            r_cool_mem <= w_mem_ready;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_mem || w_grant_if) begin
                        r_own_mem <= w_grant_mem;
                        r_we      <= w_grant_mem & mem_we;
                        r_ram_a   <= w_grant_mem ? mem_addr : if_addr;
                        r_last    <= w_grant_mem ? size_last(mem_size) : c_LAST_WORD;
                        r_cnt     <= 2'd0;
                        r_cap     <= 2'd0;
                        r_cap_vld <= 1'b0;
                        r_buf     <= '0;
                        if (w_grant_mem && mem_we) begin
                            r_wdata <= mem_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (!w_addr_last) begin
                        r_cnt   <= r_cnt + 2'd1;
                        r_ram_a <= r_ram_a + ADDR_W'(1);
                    end
                    r_cap_vld <= 1'b1;
                    if (r_cap_vld) begin
                        r_buf[{r_cap, 3'b000} +: 8] <= ram_din;
                        r_cap                       <= r_cap + 2'd1;
                    end
                end
                ST_WR: begin
                    if (!w_addr_last) begin
                        r_cnt   <= r_cnt + 2'd1;
                        r_ram_a <= r_ram_a + ADDR_W'(1);
                        r_wdata <= {8'h00, r_wdata[31:8]};
                    end
                end
                ST_DONE: begin
                    if (w_if_ready) begin
                        r_if_data <= r_buf;
                    end
                    if (w_mem_ready && !r_we) begin
                        r_mem_rdata <= r_buf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // During the ready pulse the freshly assembled word is forwarded so the
    // data is valid in the same cycle; afterwards the held copy is shown.
    assign if_ready  = w_if_ready;
    assign mem_ready = w_mem_ready;
    assign if_data   = w_if_ready ? r_buf : r_if_data;
    assign mem_rdata = (w_mem_ready && !r_we) ? r_buf : r_mem_rdata;

    assign ram_a    = r_ram_a;
    assign ram_dout = r_wdata[7:0];
    assign ram_wr   = (r_state == ST_WR) ? c_MEMORY_ENABLE : ~c_MEMORY_ENABLE;

`ifdef MEMCTRL_PERF_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_if  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (w_if_ready) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (w_mem_ready) begin
                r_perf_mem <= r_perf_mem + 32'd1;
            end
        end
    end

    assign perf_if_cnt  = r_perf_if;
    assign perf_mem_cnt = r_perf_mem;
`else
    assign perf_if_cnt  = '0;
    assign perf_mem_cnt = '0;
`endif

endmodule
`default_nettype wire
